op2_shift_seq: RTL

- Iterative operand-2 shifter for the data-processing datapath.
- Sits between the instruction decode / register-read stage and the ALU.
- Consumes instruction field bits [11:0], the I flag, Rm, Rs[7:0] and the current C flag.
- Produces the barrel-shifted operand 2 and the shifter carry-out, one bit-step per cycle, under a start/busy/done handshake.

---
 rtl/op2_shift_pkg.sv | 18 +
 rtl/op2_shift_step.sv | 45 ++++
 rtl/op2_shift_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/op2_shift_pkg.sv
// Shared constants for the operand-2 shifter.
// Shift types, FSM states and the step-count width.
package op2_shift_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/op2_shift_step.sv
// One bit-step of the operand-2 shifter.
// rrx shifts the incoming carry into the top bit.
module op2_shift_step
  import op2_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       typ,
  input  logic             rrx,
  input  logic [WIDTH-1:0] v,
  input  logic             c,
  output logic [WIDTH-1:0] v_o,
  output logic             c_o
);

  // single-bit shift; carry is always the bit shifted out
  always_comb begin
    v_o = v;
    c_o = c;
    if (rrx) begin
      v_o = {c, v[WIDTH-1:1]};
      c_o = v[0];
    end else begin
      unique case (typ)
        SH_LSL: begin
          v_o = {v[WIDTH-2:0], 1'b0};
          c_o = v[WIDTH-1];
        end
        SH_LSR: begin
          v_o = {1'b0, v[WIDTH-1:1]};
          c_o = v[0];
        end
        SH_ASR: begin
          v_o = {v[WIDTH-1], v[WIDTH-1:1]};
          c_o = v[0];
        end
        SH_ROR: begin
          v_o = {v[0], v[WIDTH-1:1]};
          c_o = v[0];
        end
      endcase
    end
  end

endmodule

// File: rtl/op2_shift_seq.sv
// Iterative operand-2 shifter with start/busy/done handshake.
// Macro OP2_DBL_STEP_EN: two bit-steps per SHIFT cycle.
module op2_shift_seq
  import op2_shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             imm_flag,
  input  logic [11:0]      instr_in,
  input  logic [WIDTH-1:0] rm_in,
  input  logic [7:0]       rs_in,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         typ_q;
  logic               rrx_q;
  logic [WIDTH-1:0]   v_q;
  logic               c_q;
  logic [WIDTH-1:0]   res_q;
  logic               co_q;
  logic               done_q;

  logic [1:0]         typ_a;
  logic               rrx_a;
  logic [WIDTH-1:0]   v_a;
  logic               c_a;
  logic [CNT_W-1:0]   n_a;

  logic [WIDTH-1:0]   v1;
  logic               c1;
  logic [WIDTH-1:0]   v_nx;
  logic               c_nx;
  logic [CNT_W-1:0]   dec;
  logic               last;

  // decode effective type, start value and step count
  always_comb begin
    typ_a = instr_in[6:5];
    rrx_a = 1'b0;
    v_a   = rm_in;
    c_a   = carry_in;
    n_a   = '0;
    if (imm_flag) begin
      typ_a = SH_ROR;
      v_a   = {{(WIDTH-8){1'b0}}, instr_in[7:0]};
      n_a   = {1'b0, instr_in[11:8], 1'b0};
    end else if (!instr_in[4]) begin
      if (instr_in[11:7] != 5'd0) begin
        n_a = {1'b0, instr_in[11:7]};
      end else begin
        unique case (instr_in[6:5])
          SH_LSL: n_a = '0;
          SH_LSR: n_a = CNT_W'(32);
          SH_ASR: n_a = CNT_W'(32);
          SH_ROR: begin
            n_a   = CNT_W'(1);
            rrx_a = 1'b1;
          end
        endcase
      end
    end else if (rs_in != 8'd0) begin
      if (instr_in[6:5] == SH_ROR) begin
        if (rs_in[4:0] == 5'd0)
          c_a = rm_in[WIDTH-1];
        else
          n_a = {1'b0, rs_in[4:0]};
      end else begin
        n_a = (rs_in > 8'd33) ? CNT_W'(33)
                              : rs_in[CNT_W-1:0];
      end
    end
  end

  op2_shift_step #(.WIDTH(WIDTH)) u_step0 (
    .typ (typ_q),
    .rrx (rrx_q),
    .v   (v_q),
    .c   (c_q),
    .v_o (v1),
    .c_o (c1)
  );

`ifdef OP2_DBL_STEP_EN
  logic [WIDTH-1:0] v2;
  logic             c2;
  logic             two;

  op2_shift_step #(.WIDTH(WIDTH)) u_step1 (
    .typ (typ_q),
    .rrx (rrx_q),
    .v   (v1),
    .c   (c1),
    .v_o (v2),
    .c_o (c2)
  );

  // take two steps while at least two remain
  always_comb begin
    two  = (cnt_q >= CNT_W'(2));
    v_nx = two ? v2 : v1;
    c_nx = two ? c2 : c1;
    dec  = two ? CNT_W'(2) : CNT_W'(1);
    last = (cnt_q <= CNT_W'(2));
  end
`else
  // one step per cycle
  always_comb begin
    v_nx = v1;
    c_nx = c1;
    dec  = CNT_W'(1);
    last = (cnt_q == CNT_W'(1));
  end
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start)
          state_d = (n_a == '0) ? ST_FINISH : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // working registers, published result and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      typ_q  <= SH_LSL;
      rrx_q  <= 1'b0;
      v_q    <= '0;
      c_q    <= 1'b0;
      res_q  <= '0;
      co_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == ST_FINISH);
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q <= n_a;
            typ_q <= typ_a;
            rrx_q <= rrx_a;
            v_q   <= v_a;
            c_q   <= c_a;
          end
        end
        ST_SHIFT: begin
          v_q   <= v_nx;
          c_q   <= c_nx;
          cnt_q <= cnt_q - dec;
        end
        ST_FINISH: begin
          res_q <= v_q;
          co_q  <= c_q;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign result    = res_q;
  assign carry_out = co_q;

endmodule
